// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for FIFO burst masters: FSM state encoding and the
// burst-length clamp used when a burst is armed.
package fifo_burst_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_BURST = 2'd2,
      ST_DRAIN = 2'd3
   } burst_state_e;

   // A zero length still moves one word; anything beyond the FIFO depth
   // could never be satisfied, so it is capped at the depth.
   function automatic logic [31:0] clamp_burst_len(input logic [31:0] len,
                                                   input logic [31:0] depth);
      logic [31:0] res;
      if (len == 32'd0)
         res = 32'd1;
      else if (len > depth)
         res = depth;
      else
         res = len;
      return res;
   endfunction

endpackage

// File: rtl/fifo_burst_reader_stream_out.sv
// Single-entry valid/ready output register. A load strobe overwrites the
// entry (even while it is being accepted); otherwise acceptance empties it.
module stream_out_reg #(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   logic             valid_d, valid_q;
   logic [WIDTH-1:0] data_d, data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst master for a show-ahead FIFO: waits for a full (or timed-out
// partial) burst, pops exactly that many words and streams them out with m_last.
module fifo_burst_reader
   import fifo_burst_reader_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8,
   parameter int TO_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [ADDR_WIDTH:0]   burst_len,
   input  logic [TO_WIDTH-1:0]   timeout,
   input  logic [ADDR_WIDTH:0]   fifo_num,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_q,
   output logic                  fifo_rd_req,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic                  burst_done
);

   localparam int LEN_W = ADDR_WIDTH + 1;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   burst_state_e          state_d, state_q;
   logic [LEN_W-1:0]      rem_d, rem_q;
   logic [LEN_W-1:0]      eff_len;
   logic [TO_WIDTH-1:0]   to_cnt_d, to_cnt_q;
   logic [TO_WIDTH:0]     to_next;
   logic                  busy_d, busy_q;
   logic                  done_d, done_q;
   logic                  pop;
   logic                  out_valid;
   logic [DATA_WIDTH:0]   out_word;

   assign eff_len = LEN_W'(clamp_burst_len(32'(burst_len), 32'(DEPTH)));
   // One bit wider so the timeout compare cannot wrap.
   assign to_next = (TO_WIDTH + 1)'(to_cnt_q) + (TO_WIDTH + 1)'(1);

   assign pop = (state_q == ST_BURST) && (rem_q != '0) && !fifo_empty &&
                (!out_valid || m_ready);

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      to_cnt_d = to_cnt_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d  = ST_ARM;
               to_cnt_d = '0;
            end
         end
         ST_ARM: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (fifo_num >= eff_len) begin
               state_d = ST_BURST;
               rem_d   = eff_len;
            end else if ((timeout != '0) && (fifo_num != '0) &&
                         (to_next >= (TO_WIDTH + 1)'(timeout))) begin
               state_d = ST_BURST;
               rem_d   = fifo_num;
            end else if (fifo_num != '0) begin
               to_cnt_d = to_next[TO_WIDTH-1:0];
            end else begin
               to_cnt_d = '0;
            end
         end
         ST_BURST: begin
            if (pop) begin
               rem_d = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1))
                  state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (out_valid && m_ready && out_word[DATA_WIDTH]) begin
               state_d  = enable ? ST_ARM : ST_IDLE;
               to_cnt_d = '0;
               done_d   = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rem_q    <= '0;
         to_cnt_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         to_cnt_q <= to_cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   stream_out_reg #(
      .WIDTH(DATA_WIDTH + 1)
   ) u_out (
      .clk      (clk),
      .rst      (rst),
      .load     (pop),
      .load_data({rem_q == LEN_W'(1), fifo_q}),
      .ready    (m_ready),
      .valid    (out_valid),
      .data     (out_word)
   );

   assign fifo_rd_req = pop;
   assign m_valid     = out_valid;
   assign m_data      = out_word[DATA_WIDTH-1:0];
   assign m_last      = out_word[DATA_WIDTH];
   assign busy        = busy_q;
   assign burst_done  = done_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based show-ahead FIFO feeds the DUT and
// a behavioural model of the burst rules predicts every output each cycle.
module tb_fifo_burst_reader;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int TW    = 16;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [AW:0]   burst_len;
   logic [TW-1:0] timeout;
   logic [AW:0]   fifo_num;
   logic          fifo_empty;
   logic [DW-1:0] fifo_q;
   logic          fifo_rd_req;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          busy;
   logic          burst_done;

   fifo_burst_reader #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .TO_WIDTH  (TW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .burst_len  (burst_len),
      .timeout    (timeout),
      .fifo_num   (fifo_num),
      .fifo_empty (fifo_empty),
      .fifo_q     (fifo_q),
      .fifo_rd_req(fifo_rd_req),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .busy       (busy),
      .burst_done (burst_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Environment: FIFO contents and the expected delivery order.
   logic [DW-1:0] fq[$];
   logic [DW-1:0] order_q[$];
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          force_empty = 1'b0;

   int            cyc = 0;
   int            acc_cnt = 0;
   int            last_cnt = 0;
   int            pop_cnt = 0;
   int            acc_first_cyc = 0;
   int            acc_last_cyc = 0;
   logic [DW-1:0] last_word = '0;

   // Reference model: phase 0 idle, 1 waiting for data, 2 sending, 3 finishing.
   int            mdl_ph = 0;
   int            mdl_left = 0;
   int            mdl_wait = 0;
   bit            mdl_have = 1'b0;
   bit            mdl_lst = 1'b0;
   logic [DW-1:0] mdl_word = '0;
   bit            mdl_done = 1'b0;

   task automatic drive_fifo();
      fifo_num   = (AW + 1)'(fq.size());
      fifo_empty = (fq.size() == 0) || force_empty;
      fifo_q     = (fq.size() != 0) ? fq[0] : '0;
   endtask

   task automatic tick();
      int            eff;
      bit            pop;
      bit            dut_pop;
      int            nph, nleft, nwait;
      bit            nhave, nlst, ndone;
      logic [DW-1:0] nword;
      @(negedge clk);
      pop = (mdl_ph == 2) && (mdl_left != 0) && !fifo_empty && (!mdl_have || m_ready);
      chk("rd_req",     32'(fifo_rd_req),  32'(pop));
      chk("m_valid",    32'(m_valid),      32'(mdl_have));
      chk("m_data",     32'(m_data),       32'(mdl_word));
      chk("m_last",     32'(m_last),       32'(mdl_lst));
      chk("busy",       32'(busy),         32'(mdl_ph != 0));
      chk("burst_done", 32'(burst_done),   32'(mdl_done));
      chk("state",      32'(dut.state_q),  32'(mdl_ph));
      if (m_valid && m_ready) begin
         acc_cnt++;
         if (acc_cnt == 1) acc_first_cyc = cyc;
         acc_last_cyc = cyc;
         if (m_last) begin
            last_cnt++;
            last_word = m_data;
         end
         if (order_q.size() == 0) chk("order_underrun", 32'(1), 32'(0));
         else chk("order", 32'(m_data), 32'(order_q.pop_front()));
      end
      if (fifo_rd_req) pop_cnt++;
      dut_pop = fifo_rd_req;

      nph = mdl_ph; nleft = mdl_left; nwait = mdl_wait;
      nhave = mdl_have; nword = mdl_word; nlst = mdl_lst; ndone = 1'b0;
      if (pop) begin
         nhave = 1'b1;
         nword = fifo_q;
         nlst  = (mdl_left == 1);
         nleft = mdl_left - 1;
         if (mdl_left == 1) nph = 3;
      end else if (mdl_have && m_ready) begin
         nhave = 1'b0;
      end
      eff = (burst_len == 0) ? 1 : ((int'(burst_len) > DEPTH) ? DEPTH : int'(burst_len));
      case (mdl_ph)
         0: if (enable) begin nph = 1; nwait = 0; end
         1: begin
            if (!enable) nph = 0;
            else if (int'(fifo_num) >= eff) begin nph = 2; nleft = eff; end
            else if (timeout != 0 && fifo_num != 0 && mdl_wait + 1 >= int'(timeout)) begin
               nph = 2; nleft = int'(fifo_num);
            end else nwait = (fifo_num != 0) ? mdl_wait + 1 : 0;
         end
         3: if (mdl_have && m_ready && mdl_lst) begin
            nph = enable ? 1 : 0; nwait = 0; ndone = 1'b1;
         end
         default: ;
      endcase

      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
         mdl_ph = 0; mdl_left = 0; mdl_wait = 0; mdl_have = 1'b0;
         mdl_lst = 1'b0; mdl_word = '0; mdl_done = 1'b0;
      end else begin
         mdl_ph = nph; mdl_left = nleft; mdl_wait = nwait; mdl_have = nhave;
         mdl_lst = nlst; mdl_word = nword; mdl_done = ndone;
      end
      if (dut_pop && fq.size() != 0) void'(fq.pop_front());
      if (wr_en && fq.size() < DEPTH) begin
         fq.push_back(wr_data);
         order_q.push_back(wr_data);
      end
      wr_en = 1'b0;
      if (rst) order_q = fq;
      drive_fifo();
   endtask

   task automatic preload(input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) begin
         wr_en   = 1'b1;
         wr_data = base + DW'(i);
         tick();
      end
   endtask

   task automatic wait_done(input int n, input int budget, input string tag);
      int seen = 0;
      int k = 0;
      while (seen < n && k < budget) begin
         tick();
         k++;
         if (burst_done) seen++;
      end
      chk(tag, 32'(seen), 32'(n));
   endtask

   task automatic wait_acc(input int n, input int budget, input string tag);
      int k = 0;
      while (acc_cnt < n && k < budget) begin
         tick();
         k++;
      end
      chk(tag, 32'(acc_cnt), 32'(n));
   endtask

   task automatic flush();
      int k = 0;
      enable = 1'b1; burst_len = 1; timeout = 0; m_ready = 1'b1;
      while ((fq.size() != 0 || m_valid) && k < 300) begin
         tick();
         k++;
      end
      chk("flush_empty", 32'(fq.size()), 32'(0));
      repeat (2) tick();
      enable = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycles=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      int wr_cyc;
      rst = 1'b1; enable = 1'b0; burst_len = 0; timeout = 0; m_ready = 1'b0;
      drive_fifo();
      @(posedge clk);
      #1;
      repeat (2) tick();
      chk("rst_m_valid",    32'(m_valid),     32'(0));
      chk("rst_busy",       32'(busy),        32'(0));
      chk("rst_m_data",     32'(m_data),      32'(0));
      chk("rst_rd_req",     32'(fifo_rd_req), 32'(0));
      chk("rst_burst_done", 32'(burst_done),  32'(0));
      rst = 1'b0;
      tick();

      // Full burst of 4 out of 6 preloaded words.
      burst_len = 4; timeout = 0; m_ready = 1'b1;
      preload(6, 8'h11);
      acc_cnt = 0; last_cnt = 0;
      enable = 1'b1;
      wait_done(1, 40, "full_done");
      chk("full_words",     32'(acc_cnt), 32'(4));
      chk("full_span",      32'(acc_last_cyc - acc_first_cyc), 32'(3));
      chk("full_last_word", 32'(last_word), 32'(8'h14));
      chk("full_fifo_left", 32'(fq.size()), 32'(2));
      chk("full_state_arm", 32'(dut.state_q), 32'(1));
      enable = 1'b0;
      repeat (2) tick();
      flush();

      // Timeout-driven short burst.
      burst_len = 8; timeout = 10; m_ready = 1'b1; enable = 1'b1;
      repeat (3) tick();
      acc_cnt = 0; last_cnt = 0;
      wr_en = 1'b1; wr_data = 8'hA0; tick();
      wr_cyc = cyc;
      wr_en = 1'b1; wr_data = 8'hA1; tick();
      wr_en = 1'b1; wr_data = 8'hA2; tick();
      k = 0;
      while (32'(dut.state_q) != 2 && k < 30) begin
         tick();
         k++;
      end
      chk("to_start_delay", 32'(cyc - wr_cyc), 32'(10));
      wait_done(1, 40, "to_done");
      chk("to_words",     32'(acc_cnt),   32'(3));
      chk("to_lasts",     32'(last_cnt),  32'(1));
      chk("to_last_word", 32'(last_word), 32'(8'hA2));
      enable = 1'b0; timeout = 0;
      repeat (3) tick();

      // Backpressure with m_ready pattern 1,0,0,1.
      burst_len = 4; m_ready = 1'b1;
      preload(4, 8'h40);
      acc_cnt = 0; pop_cnt = 0;
      enable = 1'b1;
      k = 0;
      while (!burst_done && k < 60) begin
         m_ready = (k % 4 == 0) || (k % 4 == 3);
         tick();
         k++;
      end
      chk("bp_pops",      32'(pop_cnt),   32'(4));
      chk("bp_words",     32'(acc_cnt),   32'(4));
      chk("bp_last_word", 32'(last_word), 32'(8'h43));
      m_ready = 1'b1; enable = 1'b0;
      repeat (3) tick();

      // Clamping: length 0 acts as 1, length 31 acts as 16.
      burst_len = 0; timeout = 0;
      preload(3, 8'h50);
      acc_cnt = 0; last_cnt = 0;
      enable = 1'b1;
      wait_done(3, 60, "clamp0_done");
      chk("clamp0_words", 32'(acc_cnt),  32'(3));
      chk("clamp0_lasts", 32'(last_cnt), 32'(3));
      enable = 1'b0;
      repeat (3) tick();
      burst_len = 31;
      preload(16, 8'h60);
      acc_cnt = 0; last_cnt = 0;
      enable = 1'b1;
      wait_done(1, 80, "clamp31_done");
      chk("clamp31_words",     32'(acc_cnt),   32'(16));
      chk("clamp31_lasts",     32'(last_cnt),  32'(1));
      chk("clamp31_last_word", 32'(last_word), 32'(8'h6F));
      enable = 1'b0;
      repeat (3) tick();

      // Enable dropped mid-burst: burst completes, then IDLE.
      burst_len = 4;
      preload(4, 8'h70);
      acc_cnt = 0;
      enable = 1'b1;
      wait_acc(2, 30, "drop_reach2");
      enable = 1'b0;
      wait_done(1, 30, "drop_done");
      chk("drop_words",     32'(acc_cnt),       32'(4));
      chk("drop_last_word", 32'(last_word),     32'(8'h73));
      chk("drop_idle",      32'(dut.state_q),   32'(0));
      chk("drop_busy",      32'(busy),          32'(0));

      // Reset mid-burst.
      preload(4, 8'h80);
      acc_cnt = 0;
      enable = 1'b1;
      wait_acc(2, 30, "rst_reach2");
      rst = 1'b1;
      tick();
      chk("midrst_m_valid", 32'(m_valid),     32'(0));
      chk("midrst_state",   32'(dut.state_q), 32'(0));
      rst = 1'b0; enable = 1'b0;
      tick();
      flush();

      // FIFO reports empty for 3 cycles mid-burst.
      burst_len = 6; m_ready = 1'b1;
      preload(6, 8'h90);
      acc_cnt = 0;
      enable = 1'b1;
      wait_acc(2, 30, "stall_reach2");
      force_empty = 1'b1;
      drive_fifo();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_rd_req", 32'(fifo_rd_req), 32'(0));
      end
      force_empty = 1'b0;
      drive_fifo();
      wait_done(1, 40, "stall_done");
      chk("stall_words",     32'(acc_cnt),   32'(6));
      chk("stall_last_word", 32'(last_word), 32'(8'h95));
      enable = 1'b0;
      repeat (3) tick();

      // Randomised traffic against the model.
      enable = 1'b1; burst_len = 5; timeout = 6;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 49) == 0) burst_len = (AW + 1)'($urandom_range(0, 20));
         if ($urandom_range(0, 49) == 0) timeout = TW'($urandom_range(0, 12));
         if ($urandom_range(0, 99) == 0) enable = ~enable;
         m_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 9) < 4) begin
            wr_en   = 1'b1;
            wr_data = DW'($urandom);
         end
         rst = ($urandom_range(0, 399) == 0);
         force_empty = ($urandom_range(0, 29) == 0);
         drive_fifo();
         tick();
      end
      rst = 1'b0; force_empty = 1'b0;
      drive_fifo();
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side master for a show-ahead synchronous FIFO, such as `fifo_sync`. It waits until a full burst, or a timed-out partial burst, is available in the FIFO. It then pops exactly that many words and presents them on a valid/ready output stream, with `m_last` set on the final word of each burst. It sits between a producer-filled FIFO and a burst-oriented consumer, for example a bus-master write engine or a packetiser.

## Interface
Parameters:
- `ADDR_WIDTH`, 4: FIFO address width. FIFO depth is 2**ADDR_WIDTH.
- `DATA_WIDTH`, 8: data word width.
- `TO_WIDTH`, 16: width of the timeout counter.

Ports:
- `clk` in 1: the single clock. Everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: allows new bursts to start.
- `burst_len` in ADDR_WIDTH+1: target burst size, sampled when a burst starts.
- `timeout` in TO_WIDTH: cycles to wait before sending a partial burst. 0 disables the timeout.
- `fifo_num` in ADDR_WIDTH+1: current FIFO occupancy.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_q` in DATA_WIDTH: FIFO head word, valid combinationally whenever the FIFO is not empty.
- `fifo_rd_req` out 1: pop request. The FIFO pops on the edge where this is high.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: consumer accepts the word.
- `m_data` out DATA_WIDTH: output word.
- `m_last` out 1: marks the final word of a burst.
- `busy` out 1: high when the state is not IDLE.
- `burst_done` out 1: one-cycle pulse after the last word of a burst is accepted.

## Operation
- **States:** IDLE, ARM, BURST, DRAIN.
- **IDLE → ARM** when `enable` = 1.
- **In ARM:**
  - The timeout counter `to_cnt` clears on entry.
  - `to_cnt` increments each cycle while `fifo_num` != 0, and holds at 0 while `fifo_num` = 0.
- **ARM → BURST**, loading `rem` with the effective burst length `eff_len`, when `fifo_num` >= `eff_len`.
  - `eff_len` = clamp(`burst_len`, 1, 2**ADDR_WIDTH): a value of 0 is treated as 1, and values above the depth are treated as 2**ADDR_WIDTH.
- **ARM → BURST**, loading `rem` with `fifo_num` (a short burst), when `timeout` != 0 and `to_cnt` + 1 >= `timeout` and `fifo_num` != 0.
- **ARM → IDLE** when `enable` = 0.
- **Pop condition:** `fifo_rd_req` = (state == BURST) & (`rem` != 0) & !`fifo_empty` & (!`m_valid` | `m_ready`). This is the only combinational output.
- **On a pop:**
  - Register `m_data` ← `fifo_q`.
  - Set `m_valid` ← 1.
  - Set `m_last` ← (`rem` == 1).
  - Decrement `rem`.
- **Without a pop:** if `m_ready` & `m_valid`, then `m_valid` ← 0.
- **BURST → DRAIN** on the pop that takes `rem` to 0.
- **DRAIN → ARM** (or → IDLE if `enable` = 0) when the `m_last` word is accepted. `burst_done` pulses in the cycle after that acceptance.
- **`enable` falling mid-burst:** the burst completes in full. No truncation.
- **Underflow:** the FIFO cannot underflow, because `rem` <= `fifo_num` at burst start and this block is the FIFO's only reader. If `fifo_empty` is nevertheless seen, popping stalls and no duplicate data is issued.
- **Data stability:** `m_data` and `m_last` are stable while `m_valid` & !`m_ready`.

## Timing
- **Reset values:**
  - State IDLE.
  - `m_valid`, `m_last`, `busy`, `burst_done` = 0.
  - `m_data` = 0.
  - `rem`, `to_cnt` = 0.
  - `fifo_rd_req` = 0.
- **Reset mid-burst:** the in-flight word is discarded on the next edge. Words already popped from the FIFO are lost; this is intended.
- **Start latency:** a threshold met at edge N gives BURST after N; the first pop is at N+1, so `m_valid` is high after N+1.
- **Throughput:** one word per cycle with `m_ready` held high. There are no bubbles between words of one burst.
- **Gap between bursts:** at least 2 cycles (DRAIN → ARM → BURST).
- **Timeout cycle:** the short burst starts exactly `timeout` cycles after `fifo_num` first becomes nonzero in ARM.
- **Simultaneous pop and accept:** a pop in the same cycle as `m_ready` & `m_valid` replaces the register contents; `m_valid` stays 1.

## Structure
- **Shared package/header:** state encodings (IDLE = 0, ARM = 1, BURST = 2, DRAIN = 3) and the clamp function for `burst_len`, reused by future write-side masters.
- **Sub-module:** one, `stream_out_reg`, the single-entry valid/ready output register with a load strobe. It is parameterised by DATA_WIDTH+1 to carry `m_last` alongside the data.
- **Top level:** the FSM, `rem`, and the timeout counter stay in the top module.

## Test plan
- **Full burst:**
  - Stimulus: ADDR_WIDTH = 4, `burst_len` = 4, preload FIFO with 0x11..0x16, `m_ready` = 1.
  - Required response: 0x11..0x14 on consecutive cycles, `m_last` on 0x14, one `burst_done` pulse, `fifo_num` = 2 left, state ARM.
- **Timeout short burst:**
  - Stimulus: `burst_len` = 8, `timeout` = 10, write 3 words.
  - Required response: burst starts 10 cycles after the first write, 3 words out, `m_last` on the third.
- **Backpressure:**
  - Stimulus: `burst_len` = 4, `m_ready` toggling 1,0,0,1,...
  - Required response: no pop while `m_valid` & !`m_ready`, `m_data` stable while stalled, order preserved, exactly 4 pops.
- **Clamping and disabled timeout:**
  - Stimulus: `burst_len` = 0 with `timeout` = 0, then `burst_len` = 31 with a full FIFO of 16 words.
  - Required response: single-word bursts first, then one 16-word burst.
- **`enable` drop and reset:**
  - Stimulus: drop `enable` at word 2 of a 4-word burst.
  - Required response: all 4 words are delivered, then IDLE.
  - Stimulus: assert `rst` at word 2 of another 4-word burst.
  - Required response: `m_valid` = 0 and state IDLE on the next edge.
- **Empty stall:**
  - Stimulus: force `fifo_empty` = 1 for 3 cycles mid-burst.
  - Required response: `fifo_rd_req` = 0 throughout, no duplicate words, burst resumes afterwards.
